// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first with 1 or 2 stop bits, CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to insert a parity bit (even/odd via PARITY_ODD) after data bit 7.
module uart_tx #(
   parameter int CLKS_PER_BIT = 217,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic       i_Clock,
   input  logic       i_Rst_L,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   output logic       o_TX_Active,
   output logic       o_TX_Serial,
   output logic       o_TX_Done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] ONE_CLK   = CW'(1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   generate
      if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
          (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
         $error("uart_tx: illegal parameter value");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY  = 3'd3,
`endif
      S_STOP    = 3'd4,
      S_CLEANUP = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic            stop_cnt_q, stop_cnt_d;
   logic [7:0]      byte_q, byte_d;
   logic            serial_q, serial_d;
   logic            active_q, active_d;
   logic            done_q, done_d;
   logic            clk_last;

`ifdef UART_TX_PARITY_EN
   function automatic logic parity_bit(input logic [7:0] b);
      return (PARITY_ODD != 0) ? ~^b : ^b;
   endfunction
`endif

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= S_IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         stop_cnt_q <= 1'b0;
         byte_q     <= '0;
         serial_q   <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         byte_q     <= byte_d;
         serial_q   <= serial_d;
         active_q   <= active_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic computes the value each output register takes at the coming edge.
   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      byte_d     = byte_q;
      serial_d   = serial_q;
      active_d   = active_q;
      done_d     = 1'b0;
      clk_last   = (clk_cnt_q == LAST_CLK);

      case (state_q)
         S_IDLE: begin
            serial_d   = 1'b1;
            active_d   = 1'b0;
            clk_cnt_d  = '0;
            bit_idx_d  = '0;
            stop_cnt_d = 1'b0;
            if (i_TX_DV) begin
               byte_d   = i_TX_Byte;
               active_d = 1'b1;
               serial_d = 1'b0;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (clk_last) begin
               clk_cnt_d = '0;
               serial_d  = byte_q[0];
               state_d   = S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + ONE_CLK;
            end
         end
         S_DATA: begin
            if (clk_last) begin
               clk_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  serial_d  = parity_bit(byte_q);
                  state_d   = S_PARITY;
`else
                  serial_d  = 1'b1;
                  state_d   = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  serial_d  = byte_q[bit_idx_q + 3'd1];
               end
            end else begin
               clk_cnt_d = clk_cnt_q + ONE_CLK;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (clk_last) begin
               clk_cnt_d = '0;
               serial_d  = 1'b1;
               state_d   = S_STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + ONE_CLK;
            end
         end
`endif
         S_STOP: begin
            if (clk_last) begin
               clk_cnt_d = '0;
               if (stop_cnt_q == LAST_STOP) begin
                  stop_cnt_d = 1'b0;
                  done_d     = 1'b1;
                  active_d   = 1'b0;
                  state_d    = S_CLEANUP;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + ONE_CLK;
            end
         end
         S_CLEANUP: begin
            serial_d = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            serial_d = 1'b1;
            active_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   assign o_TX_Serial = serial_q;
   assign o_TX_Active = active_q;
   assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4; one instance per stop-bit/parity configuration.
// Parity instances are present only when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dv;
   logic [7:0] tx_byte;

   logic act_s1, ser_s1, done_s1;
   logic act_s2, ser_s2, done_s2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_s1 (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
      .o_TX_Active(act_s1), .o_TX_Serial(ser_s1), .o_TX_Done(done_s1));

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(0)) dut_s2 (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
      .o_TX_Active(act_s2), .o_TX_Serial(ser_s2), .o_TX_Done(done_s2));

`ifdef UART_TX_PARITY_EN
   logic act_pe, ser_pe, done_pe;
   logic act_po, ser_po, done_po;

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_pe (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
      .o_TX_Active(act_pe), .o_TX_Serial(ser_pe), .o_TX_Done(done_pe));

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1)) dut_po (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
      .o_TX_Active(act_po), .o_TX_Serial(ser_po), .o_TX_Done(done_po));
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      logic [9:0]  frame;
      logic [9:0]  frame2;
      logic [7:0]  rx0;
      logic [7:0]  rx1;
`ifdef UART_TX_PARITY_EN
      logic [10:0] frame_e;
      logic [10:0] frame_o;
      logic [7:0]  rxp;
`endif

      rst_n   = 1'b0;
      dv      = 1'b0;
      tx_byte = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_serial_s1", 32'(ser_s1), 32'd1);
      check("rst_active_s1", 32'(act_s1), 32'd0);
      check("rst_done_s1", 32'(done_s1), 32'd0);
      check("rst_serial_s2", 32'(ser_s2), 32'd1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_serial_s1", 32'(ser_s1), 32'd1);

      // 0xA5 frame with an ignored 0x3C request in the middle.
      frame   = 10'b1_1010_0101_0;
      tx_byte = 8'hA5;
      dv      = 1'b1;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (t == 0)  dv = 1'b0;
         if (t == 10) begin dv = 1'b1; tx_byte = 8'h3C; end
         if (t == 11) dv = 1'b0;
         check($sformatf("a5_active_t%0d", t), 32'(act_s1), 32'(t < 40));
         check($sformatf("a5_done_t%0d", t), 32'(done_s1), 32'(t == 40));
         if ((t % 4) == 2 && t < 40)
            check($sformatf("a5_bit%0d", t / 4), 32'(ser_s1), 32'(frame[t / 4]));
         if (t >= 40)
            check($sformatf("a5_idle_line_t%0d", t), 32'(ser_s1), 32'd1);
      end

      // Back-to-back: DV held high, byte changed right after acceptance.
      frame   = 10'b1_0000_0000_0;
      frame2  = 10'b1_1111_1111_0;
      rx0     = 8'h5A;
      rx1     = 8'h5A;
      tx_byte = 8'h00;
      dv      = 1'b1;
      for (int t = 0; t < 96; t++) begin
         @(negedge clk);
         if (t == 0)  tx_byte = 8'hFF;
         if (t == 42) dv = 1'b0;
         check($sformatf("b2b_active_t%0d", t), 32'(act_s1),
               32'((t < 40) || (t >= 42 && t < 82)));
         check($sformatf("b2b_done_t%0d", t), 32'(done_s1), 32'(t == 40 || t == 82));
         if ((t % 4) == 2 && t < 40) begin
            check($sformatf("b2b_f1_bit%0d", t / 4), 32'(ser_s1), 32'(frame[t / 4]));
            if (t / 4 >= 1 && t / 4 <= 8) rx0[t / 4 - 1] = ser_s1;
         end
         if (t == 40 || t == 41)
            check($sformatf("b2b_gap_t%0d", t), 32'(ser_s1), 32'd1);
         if (t == 42)
            check("b2b_second_start", 32'(ser_s1), 32'd0);
         if (t >= 42 && ((t - 42) % 4) == 2 && t < 82) begin
            check($sformatf("b2b_f2_bit%0d", (t - 42) / 4), 32'(ser_s1),
                  32'(frame2[(t - 42) / 4]));
            if ((t - 42) / 4 >= 1 && (t - 42) / 4 <= 8) rx1[(t - 42) / 4 - 1] = ser_s1;
         end
      end
      check("b2b_rx0", 32'(rx0), 32'h00);
      check("b2b_rx1", 32'(rx1), 32'hFF);

      // Two stop bits on dut_s2 with 0x81.
      frame   = 10'b1_1000_0001_0;
      tx_byte = 8'h81;
      dv      = 1'b1;
      for (int t = 0; t < 56; t++) begin
         @(negedge clk);
         if (t == 0) dv = 1'b0;
         check($sformatf("s2_active_t%0d", t), 32'(act_s2), 32'(t < 44));
         check($sformatf("s2_done_t%0d", t), 32'(done_s2), 32'(t == 44));
         if ((t % 4) == 2 && t < 36)
            check($sformatf("s2_bit%0d", t / 4), 32'(ser_s2), 32'(frame[t / 4]));
         if (t >= 36)
            check($sformatf("s2_stop_line_t%0d", t), 32'(ser_s2), 32'd1);
      end

`ifdef UART_TX_PARITY_EN
      // 0xA5 has four ones: even parity 0, odd parity 1.
      frame_e = 11'b1_0_1010_0101_0;
      frame_o = 11'b1_1_1010_0101_0;
      rxp     = 8'h00;
      tx_byte = 8'hA5;
      dv      = 1'b1;
      for (int t = 0; t < 56; t++) begin
         @(negedge clk);
         if (t == 0) dv = 1'b0;
         check($sformatf("par_done_e_t%0d", t), 32'(done_pe), 32'(t == 44));
         check($sformatf("par_done_o_t%0d", t), 32'(done_po), 32'(t == 44));
         check($sformatf("par_active_e_t%0d", t), 32'(act_pe), 32'(t < 44));
         if ((t % 4) == 2 && t < 44) begin
            check($sformatf("par_e_bit%0d", t / 4), 32'(ser_pe), 32'(frame_e[t / 4]));
            check($sformatf("par_o_bit%0d", t / 4), 32'(ser_po), 32'(frame_o[t / 4]));
            if (t / 4 >= 1 && t / 4 <= 8) rxp[t / 4 - 1] = ser_pe;
         end
      end
      check("par_loopback_byte", 32'(rxp), 32'hA5);
`endif

      // Reset in the middle of a 0x00 frame.
      tx_byte = 8'h00;
      dv      = 1'b1;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (t == 0) dv = 1'b0;
         if (t == 4)
            check("mid_line_low", 32'(ser_s1), 32'd0);
         if (t == 6) begin
            rst_n = 1'b0;
            #1;
            check("mid_rst_serial", 32'(ser_s1), 32'd1);
            check("mid_rst_active", 32'(act_s1), 32'd0);
            check("mid_rst_done", 32'(done_s1), 32'd0);
         end
         if (t == 8) rst_n = 1'b1;
         if (t > 6) begin
            check($sformatf("post_rst_done_t%0d", t), 32'(done_s1), 32'd0);
            check($sformatf("post_rst_active_t%0d", t), 32'(act_s1), 32'd0);
            check($sformatf("post_rst_serial_t%0d", t), 32'(ser_s1), 32'd1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
